// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants, the fetch queue entry type and address helpers
// used by the instruction-fetch stage.
//   XLEN           address / instruction width
//   PC_STEP        byte increment between sequential fetches
//   IMEM_SIZE_WORD access-size code presented to the instruction memory
//   NOP_INST       filler instruction held by queue storage out of reset
//   fetch_entry_t  {pc, inst} pair buffered between fetch and decode
package fetch_pkg;

  localparam int          XLEN           = 32;
  localparam logic [31:0] PC_STEP        = 32'd4;
  localparam logic [1:0]  IMEM_SIZE_WORD = 2'b10;
  localparam logic [31:0] NOP_INST       = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  // Clear the byte-offset bits so the result is a word address.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & {{(XLEN-2){1'b1}}, 2'b00};
  endfunction

  // True when the address is not on a word boundary.
  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return (addr & {{(XLEN-2){1'b0}}, 2'b11}) != {XLEN{1'b0}};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bus bundle between the fetch stage, the instruction memory and
// decode.
//   imem_addr  word address presented to the instruction memory
//   imem_size  access-size code (always word)
//   imem_data  instruction word returned combinationally for imem_addr
//   out_valid  queue head valid toward decode
//   out_ready  decode accepts the head
//   out_inst   head instruction
//   out_pc     PC of the head instruction
// master = fetch stage, slave = memory/decode side.
interface fetch_unit_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] imem_addr;
  logic [1:0]      imem_size;
  logic [XLEN-1:0] imem_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_inst;
  logic [XLEN-1:0] out_pc;

  modport master (
    output imem_addr, imem_size, out_valid, out_inst, out_pc,
    input  imem_data, out_ready
  );

  modport slave (
    input  imem_addr, imem_size, out_valid, out_inst, out_pc,
    output imem_data, out_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: small synchronous FIFO of fetch_entry_t between fetch and decode.
//   CLK        clock, rising edge
//   RST        synchronous active-high reset
//   flush      discard all entries (wins over push and pop)
//   push       write push_data (ignored when full with no pop)
//   push_data  entry to write
//   pop        drop the head entry (ignored when empty)
//   head       current head entry (stale when empty)
//   valid      head entry valid
//   count      number of held entries
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       flush,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  output fetch_entry_t               head,
  output logic                       valid,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t    mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic            push_s;
  logic            pop_s;

  // Qualify push/pop against the current fill level.
  always_comb begin
    pop_s  = pop && (count_r != {CW{1'b0}});
    push_s = push && ((count_r < CW'(DEPTH)) || pop_s);
  end

  // Storage, pointers and fill count.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '{pc: {XLEN{1'b0}}, inst: NOP_INST};
      end
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign valid = (count_r != {CW{1'b0}});
  assign count = count_r;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the PC, drives the word address to
// the instruction memory, and queues {pc, inst} pairs toward decode.
//   CLK             clock, rising edge
//   RST             synchronous active-high reset
//   halt            stop issuing fetches (queue still drains)
//   redirect_valid  flush queue and restart fetch at redirect_pc (top priority)
//   redirect_pc     redirect target; low two bits are dropped
//   misalign_err    one-cycle pulse after a redirect to a non-word address
//   bus (master)    imem_addr/imem_size/imem_data and out_valid/ready/inst/pc
// Optional build macro FETCH_BYPASS_EN: with an empty queue the fetched word is
// presented to decode in the same cycle and, if accepted, never enters the queue.
module fetch_unit #(
  parameter int          XLEN        = 32,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             halt,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic             misalign_err,
  fetch_unit_if.master     bus
);
  import fetch_pkg::*;

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  logic [XLEN-1:0] pc_r;
  logic            misalign_r;

  fetch_entry_t    q_head_s;
  fetch_entry_t    q_push_data_s;
  logic            q_valid_s;
  logic [CW-1:0]   q_count_s;
  logic            q_pop_s;
  logic            q_push_s;
  logic            fetch_s;
`ifdef FETCH_BYPASS_EN
  logic            bypass_s;
`endif

  // Handshake and fetch decision; a pop in a redirect cycle is void because the
  // queue is flushed anyway.
  always_comb begin
    q_pop_s       = q_valid_s && bus.out_ready && !redirect_valid;
    fetch_s       = !halt && !redirect_valid &&
                    ((q_count_s < CW'(QUEUE_DEPTH)) || q_pop_s);
    q_push_data_s = '{pc: pc_r, inst: bus.imem_data};
`ifdef FETCH_BYPASS_EN
    bypass_s      = fetch_s && !q_valid_s;
    q_push_s      = fetch_s && !(bypass_s && bus.out_ready);
`else
    q_push_s      = fetch_s;
`endif
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .CLK       (CLK),
    .RST       (RST),
    .flush     (redirect_valid),
    .push      (q_push_s),
    .push_data (q_push_data_s),
    .pop       (q_pop_s),
    .head      (q_head_s),
    .valid     (q_valid_s),
    .count     (q_count_s)
  );

  // PC sequencing and misalignment flag; reset beats redirect beats fetch.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_r       <= word_align(RESET_PC);
      misalign_r <= 1'b0;
    end else if (redirect_valid) begin
      pc_r       <= word_align(redirect_pc);
      misalign_r <= is_misaligned(redirect_pc);
    end else begin
      misalign_r <= 1'b0;
      if (fetch_s) begin
        pc_r <= pc_r + XLEN'(PC_STEP);
      end
    end
  end

  // Decode-facing outputs.
  always_comb begin
`ifdef FETCH_BYPASS_EN
    if (bypass_s) begin
      bus.out_valid = 1'b1;
      bus.out_inst  = bus.imem_data;
      bus.out_pc    = pc_r;
    end else begin
      bus.out_valid = q_valid_s && !redirect_valid;
      bus.out_inst  = q_head_s.inst;
      bus.out_pc    = q_head_s.pc;
    end
`else
    bus.out_valid = q_valid_s;
    bus.out_inst  = q_head_s.inst;
    bus.out_pc    = q_head_s.pc;
`endif
  end

  assign bus.imem_addr = pc_r;
  assign bus.imem_size = IMEM_SIZE_WORD;
  assign misalign_err  = misalign_r;

endmodule
